// File: rtl/locking_rr_arbiter_n_pkg.sv
// rtl/locking_rr_arbiter_n_pkg.sv - shared constants and width helpers for the locking arbiter
package locking_rr_arbiter_n_pkg;

    localparam int DATA_W_DEFAULT = 101;
    localparam int N_IN_MAX       = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index and counter widths never collapse to zero bits
    function automatic int idx_width(input int n_in);
        return (clog2(n_in) < 1) ? 1 : clog2(n_in);
    endfunction

    function automatic int cnt_width(input int beats);
        return (clog2(beats) < 1) ? 1 : clog2(beats);
    endfunction

    typedef logic [clog2(N_IN_MAX)-1:0] chan_idx_t;

endpackage

// File: rtl/locking_rr_arbiter_n_if.sv
// rtl/locking_rr_arbiter_n_if.sv - client-side channels and shared output port of the arbiter
interface locking_rr_arbiter_n_if
    import locking_rr_arbiter_n_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    localparam int IDX_W = idx_width(N_IN);

    logic [N_IN-1:0]        io_in_valid;
    logic [N_IN-1:0]        io_in_ready;
    logic [N_IN*DATA_W-1:0] io_in_bits;
    logic [N_IN-1:0]        io_in_multibeat;
    logic [N_IN-1:0]        io_in_mask;
    logic                   io_out_ready;
    logic                   io_out_valid;
    logic [DATA_W-1:0]      io_out_bits;
    logic [IDX_W-1:0]       io_chosen;
    logic                   io_locked;

    modport slave (
        input  io_in_valid, io_in_bits, io_in_multibeat, io_in_mask, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_chosen, io_locked
    );

    modport master (
        output io_in_valid, io_in_bits, io_in_multibeat, io_in_mask, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_chosen, io_locked
    );

endinterface

// File: rtl/locking_rr_arbiter_n_rr_priority_select.sv
// rtl/locking_rr_arbiter_n_rr_priority_select.sv - round-robin pick of the next eligible channel
module locking_rr_arbiter_n_rr_priority_select #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_IN-1:0]  i_elig,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [IDX_W-1:0] o_choice
);

    logic             w_hi_found;
    logic             w_lo_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Scanning downwards leaves the lowest matching index in each candidate
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = IDX_W'(N_IN - 1);
        w_lo_idx   = IDX_W'(N_IN - 1);
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDX_W'(i);
                if (IDX_W'(i) > i_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end
            end
        end
        if (w_hi_found) begin
            o_choice = w_hi_idx;
        end else if (w_lo_found) begin
            o_choice = w_lo_idx;
        end else begin
            o_choice = IDX_W'(N_IN - 1);
        end
    end

endmodule

// File: rtl/locking_rr_arbiter_n.sv
// rtl/locking_rr_arbiter_n.sv - N-input round-robin arbiter that locks onto multibeat bursts
module locking_rr_arbiter_n
    import locking_rr_arbiter_n_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int BEATS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    locking_rr_arbiter_n_if.slave io
);

    localparam int IDX_W   = idx_width(N_IN);
    localparam int CNT_W   = cnt_width(BEATS);
    localparam bit LOCK_EN = (BEATS > 1);

    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  r_lock_idx;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [N_IN-1:0]   w_elig;
    logic [IDX_W-1:0]  w_choice;
    logic [IDX_W-1:0]  w_chosen;
    logic              w_locked;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_bits;
    logic              w_multibeat;
    logic [N_IN-1:0]   w_in_ready;
    logic              w_fire;

    assign w_elig   = io.io_in_valid & io.io_in_mask;
    assign w_locked = (r_beat_cnt != '0);
    assign w_chosen = w_locked ? r_lock_idx : w_choice;

    locking_rr_arbiter_n_rr_priority_select #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_select (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_choice     (w_choice)
    );

    always_comb begin
        w_out_valid = 1'b0;
        w_out_bits  = '0;
        w_multibeat = 1'b0;
        w_in_ready  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_chosen == IDX_W'(i)) begin
                w_out_valid   = io.io_in_valid[i];
                w_out_bits    = io.io_in_bits[i*DATA_W +: DATA_W];
                w_multibeat   = io.io_in_multibeat[i];
                w_in_ready[i] = io.io_out_ready;
            end
        end
    end

    assign w_fire          = w_out_valid & io.io_out_ready;
    assign io.io_out_valid = w_out_valid;
    assign io.io_out_bits  = w_out_bits;
    assign io.io_in_ready  = w_in_ready;
    assign io.io_chosen    = w_chosen;
    assign io.io_locked    = w_locked;

    // Counter wraps at BEATS-1 explicitly so non-power-of-two bursts unlock on time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= IDX_W'(N_IN - 1);
            r_lock_idx   <= '0;
            r_beat_cnt   <= '0;
        end else if (w_fire) begin
            r_last_grant <= w_chosen;
            if (w_locked) begin
                if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end else if (LOCK_EN && w_multibeat) begin
                r_lock_idx <= w_chosen;
                r_beat_cnt <= CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_locking_rr_arbiter_n.sv
// tb/tb_locking_rr_arbiter_n.sv - scoreboard bench for the locking round-robin arbiter
module tb_locking_rr_arbiter_n;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    locking_rr_arbiter_n_if #(.N_IN(4), .DATA_W(DW)) m_if ();
    locking_rr_arbiter_n_if #(.N_IN(3), .DATA_W(8))  if3 ();
    locking_rr_arbiter_n_if #(.N_IN(2), .DATA_W(8))  if2 ();

    locking_rr_arbiter_n #(.N_IN(4), .DATA_W(DW), .BEATS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (m_if.slave)
    );

    locking_rr_arbiter_n #(.N_IN(3), .DATA_W(8), .BEATS(5)) dut3 (
        .clk   (clk),
        .reset (reset),
        .io    (if3.slave)
    );

    locking_rr_arbiter_n #(.N_IN(2), .DATA_W(8), .BEATS(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .io    (if2.slave)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] bits;
    } exp_t;

    exp_t       sb_q[$];
    int         q3[$];
    int         q2[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] tag;

    function automatic logic [DW-1:0] payload(input int ch, input logic [7:0] t);
        return {4'(ch), 4'hA, t};
    endfunction

    task automatic drive_bits();
        for (int i = 0; i < 4; i++) m_if.io_in_bits[i*DW +: DW] = payload(i, tag);
    endtask

    task automatic push(input int ch, input int count);
        repeat (count) sb_q.push_back('{ch, payload(ch, tag)});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tag = 8'h00;
        drive_bits();
        m_if.io_in_valid = '0;
        m_if.io_in_multibeat = '0;
        m_if.io_in_mask = 4'hF;
        m_if.io_out_ready = 1'b1;
        if3.io_in_valid = '0;
        if3.io_in_multibeat = '0;
        if3.io_in_mask = 3'b111;
        if3.io_in_bits = {8'h32, 8'h31, 8'h30};
        if3.io_out_ready = 1'b1;
        if2.io_in_valid = '0;
        if2.io_in_multibeat = '0;
        if2.io_in_mask = 2'b11;
        if2.io_in_bits = {8'h21, 8'h20};
        if2.io_out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_if.io_locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b want=0", m_if.io_locked); end
        n_cmp++;
        if (m_if.io_chosen !== 2'd3) begin n_err++; $display("FAIL reset_chosen got=%0d want=3", m_if.io_chosen); end
        n_cmp++;
        if (m_if.io_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", m_if.io_out_valid); end
        n_cmp++;
        if (m_if.io_in_ready !== 4'b1000) begin n_err++; $display("FAIL reset_ready got=%b want=1000", m_if.io_in_ready); end
        n_cmp++;
        if (if3.io_chosen !== 2'd2 || if3.io_locked !== 1'b0) begin n_err++; $display("FAIL reset_dut3 chosen=%0d locked=%b want 2/0", if3.io_chosen, if3.io_locked); end
        n_cmp++;
        if (if2.io_chosen !== 1'd1 || if2.io_locked !== 1'b0) begin n_err++; $display("FAIL reset_dut2 chosen=%0d locked=%b want 1/0", if2.io_chosen, if2.io_locked); end
        m_if.io_in_valid = 4'b0010;
        #1;
        n_cmp++;
        if (m_if.io_chosen !== 2'd1) begin n_err++; $display("FAIL reset_choice got=%0d want=1", m_if.io_chosen); end
        m_if.io_in_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        @(negedge clk);
        tag = 8'h11;
        drive_bits();
        m_if.io_in_valid = 4'b0101;
        m_if.io_in_multibeat = '0;
        push(0, 1); push(2, 1); push(0, 1); push(2, 1); push(0, 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits || m_if.io_in_ready !== (4'b0001 << e.idx)) begin
                    n_err++;
                    $display("FAIL rr_grant c=%0d chosen=%0d bits=%h ready=%b want chosen=%0d bits=%h", c, m_if.io_chosen, m_if.io_out_bits, m_if.io_in_ready, e.idx, e.bits);
                end
            end else begin
                n_err++;
                $display("FAIL rr_grant c=%0d valid=%b queued=%0d want a fire", c, m_if.io_out_valid, sb_q.size());
            end
        end
    endtask

    task automatic test_burst_lock();
        exp_t e;
        @(negedge clk);
        tag = 8'h22;
        drive_bits();
        m_if.io_in_valid = 4'b1010;
        m_if.io_in_multibeat = 4'b0010;
        push(1, 8); push(3, 1);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits) begin
                    n_err++;
                    $display("FAIL burst_grant c=%0d chosen=%0d bits=%h want chosen=%0d bits=%h", c, m_if.io_chosen, m_if.io_out_bits, e.idx, e.bits);
                end
            end else begin
                n_err++;
                $display("FAIL burst_grant c=%0d valid=%b queued=%0d want a fire", c, m_if.io_out_valid, sb_q.size());
            end
            n_cmp++;
            if (m_if.io_locked !== ((c >= 1 && c <= 7) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL burst_locked c=%0d got=%b", c, m_if.io_locked);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        @(negedge clk);
        tag = 8'h33;
        drive_bits();
        m_if.io_in_multibeat = 4'b0010;
        push(1, 8); push(3, 1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            m_if.io_in_valid = (c >= 4 && c < 7) ? 4'b1000 : 4'b1010;
            #1;
            if (c >= 4 && c < 7) begin
                n_cmp++;
                if (m_if.io_out_valid !== 1'b0 || m_if.io_in_ready[3] !== 1'b0 || m_if.io_chosen !== 2'd1 || m_if.io_locked !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold c=%0d valid=%b ready=%b chosen=%0d locked=%b want 0/0xxx/1/1", c, m_if.io_out_valid, m_if.io_in_ready, m_if.io_chosen, m_if.io_locked);
                end
            end else begin
                n_cmp++;
                if (m_if.io_out_valid && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits) begin
                        n_err++;
                        $display("FAIL stall_grant c=%0d chosen=%0d bits=%h want chosen=%0d bits=%h", c, m_if.io_chosen, m_if.io_out_bits, e.idx, e.bits);
                    end
                end else begin
                    n_err++;
                    $display("FAIL stall_grant c=%0d valid=%b queued=%0d want a fire", c, m_if.io_out_valid, sb_q.size());
                end
                n_cmp++;
                if (m_if.io_locked !== ((c >= 1 && c != 11) ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("FAIL stall_locked c=%0d got=%b", c, m_if.io_locked);
                end
            end
        end
    endtask

    task automatic test_mask();
        exp_t e;
        @(negedge clk);
        tag = 8'h44;
        drive_bits();
        m_if.io_in_mask = 4'b1011;
        m_if.io_in_valid = 4'b1100;
        m_if.io_in_multibeat = '0;
        push(3, 4);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits || m_if.io_in_ready[2] !== 1'b0) begin
                    n_err++;
                    $display("FAIL mask_grant c=%0d chosen=%0d ready=%b want chosen=%0d", c, m_if.io_chosen, m_if.io_in_ready, e.idx);
                end
            end else begin
                n_err++;
                $display("FAIL mask_grant c=%0d valid=%b queued=%0d want a fire", c, m_if.io_out_valid, sb_q.size());
            end
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                m_if.io_in_mask = 4'b1111;
                m_if.io_in_valid = 4'b1010;
                m_if.io_in_multibeat = 4'b0010;
                push(1, 8); push(3, 1);
            end
            if (c == 2) m_if.io_in_mask = 4'b1001;
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits) begin
                    n_err++;
                    $display("FAIL mask_lock_grant c=%0d chosen=%0d want=%0d", c, m_if.io_chosen, e.idx);
                end
            end else begin
                n_err++;
                $display("FAIL mask_lock_grant c=%0d valid=%b queued=%0d want a fire", c, m_if.io_out_valid, sb_q.size());
            end
            n_cmp++;
            if (m_if.io_locked !== ((c >= 1 && c <= 7) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL mask_lock_locked c=%0d got=%b", c, m_if.io_locked);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        tag = 8'h55;
        drive_bits();
        m_if.io_in_mask = 4'b1111;
        m_if.io_in_valid = 4'b0010;
        m_if.io_in_multibeat = 4'b0010;
        push(1, 5);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx) begin
                    n_err++;
                    $display("FAIL areset_burst c=%0d chosen=%0d want=%0d", c, m_if.io_chosen, e.idx);
                end
            end else begin
                n_err++;
                $display("FAIL areset_burst c=%0d valid=%b want a fire", c, m_if.io_out_valid);
            end
        end
        @(negedge clk);
        m_if.io_in_valid = 4'b0011;
        #1;
        n_cmp++;
        if (m_if.io_locked !== 1'b1 || m_if.io_chosen !== 2'd1) begin
            n_err++;
            $display("FAIL areset_pre locked=%b chosen=%0d want 1/1", m_if.io_locked, m_if.io_chosen);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (m_if.io_locked !== 1'b0 || m_if.io_chosen !== 2'd0) begin
            n_err++;
            $display("FAIL areset_drop locked=%b chosen=%0d want 0/0", m_if.io_locked, m_if.io_chosen);
        end
        @(negedge clk);
        reset = 1'b0;
        m_if.io_in_multibeat = '0;
        push(0, 1); push(1, 1);
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (m_if.io_out_valid && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (int'(m_if.io_chosen) !== e.idx || m_if.io_out_bits !== e.bits || m_if.io_locked !== 1'b0) begin
                    n_err++;
                    $display("FAIL areset_after c=%0d chosen=%0d locked=%b want chosen=%0d", c, m_if.io_chosen, m_if.io_locked, e.idx);
                end
            end else begin
                n_err++;
                $display("FAIL areset_after c=%0d valid=%b want a fire", c, m_if.io_out_valid);
            end
        end
    endtask

    task automatic test_small_builds();
        int e3;
        int e2;
        @(negedge clk);
        m_if.io_in_valid = '0;
        if3.io_in_valid = 3'b100;
        if3.io_in_multibeat = 3'b100;
        if2.io_in_valid = 2'b11;
        if2.io_in_multibeat = 2'b11;
        repeat (5) q3.push_back(2);
        for (int k = 0; k < 3; k++) begin q2.push_back(0); q2.push_back(1); end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) if3.io_out_ready = 1'b0;
            #1;
            if (c < 5) begin
                n_cmp++;
                if (if3.io_out_valid && q3.size() > 0) begin
                    e3 = q3.pop_front();
                    if (int'(if3.io_chosen) !== e3 || if3.io_out_bits !== (8'h30 + 8'(e3))) begin
                        n_err++;
                        $display("FAIL b5_grant c=%0d chosen=%0d bits=%h want=%0d", c, if3.io_chosen, if3.io_out_bits, e3);
                    end
                end else begin
                    n_err++;
                    $display("FAIL b5_grant c=%0d valid=%b want a fire", c, if3.io_out_valid);
                end
            end
            n_cmp++;
            if (if3.io_locked !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL b5_locked c=%0d got=%b", c, if3.io_locked);
            end
            n_cmp++;
            if (if2.io_out_valid && q2.size() > 0) begin
                e2 = q2.pop_front();
                if (int'(if2.io_chosen) !== e2 || if2.io_out_bits !== (8'h20 + 8'(e2)) || if2.io_locked !== 1'b0) begin
                    n_err++;
                    $display("FAIL b1_grant c=%0d chosen=%0d locked=%b want chosen=%0d locked=0", c, if2.io_chosen, if2.io_locked, e2);
                end
            end else begin
                n_err++;
                $display("FAIL b1_grant c=%0d valid=%b want a fire", c, if2.io_out_valid);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_stall();
        test_mask();
        test_async_reset();
        test_small_builds();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain left=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
